fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V core. It owns the program counter and issues single-outstanding requests to instruction memory. It buffers one fetched instruction toward decode. It applies control-flow redirects from execute: conditional branches qualified by the branch-control decision, plus JAL/JALR. It drops stale instructions on redirect.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch stage with single-outstanding imem requests
// Owns the PC, buffers one instruction toward decode and applies execute redirects.
module fetch_unit #(
  parameter int unsigned   DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ex_valid_i,
  input  logic          ex_is_branch_i,
  input  logic          branch_i,
  input  logic          ex_jal_i,
  input  logic          ex_jalr_i,
  input  logic [DW-1:0] ex_pc_i,
  input  logic [DW-1:0] ex_imm_i,
  input  logic [DW-1:0] ex_rs1_i,
  output logic          redirect_o,
  output logic          misalign_o,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [31:0]   imem_rdata_i,
  output logic          if_valid_o,
  output logic [31:0]   if_instr_o,
  output logic [DW-1:0] if_pc_o,
  input  logic          id_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] out_addr_q, out_addr_d;
  logic          kill_q, kill_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] ipc_q, ipc_d;
  logic          mis_q;
  logic [DW-1:0] sum_br, sum_jalr, tgt_raw, tgt;
  logic          redirect, buf_free;

  assign redirect = ex_valid_i & ((ex_is_branch_i & branch_i) | ex_jal_i | ex_jalr_i);
  assign sum_br   = ex_pc_i + ex_imm_i;
  assign sum_jalr = (ex_rs1_i + ex_imm_i) & ~DW'(1);
  assign tgt_raw  = ex_jalr_i ? sum_jalr : sum_br;
  assign tgt      = tgt_raw & ~DW'(3);
  assign buf_free = ~valid_q | id_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_addr_d = out_addr_q;
    kill_d     = kill_q;
    valid_d    = valid_q & ~id_ready_i;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    case (state_q)
      S_IDLE: begin
        if (buf_free | redirect) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) kill_d = 1'b1;
        if (imem_gnt_i) begin
          state_d    = S_WAIT;
          out_addr_d = addr_q;
          if (!kill_q) pc_d = pc_q + DW'(4);
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (redirect | kill_q) begin
            state_d = (redirect | buf_free) ? S_REQ : S_IDLE;
          end else if (buf_free) begin
            valid_d = 1'b1;
            instr_d = imem_rdata_i;
            ipc_d   = out_addr_q;
            state_d = S_REQ;
          end else begin
            // Decode still holds the previous entry: drop this word and refetch it later.
            pc_d    = out_addr_q;
            state_d = S_IDLE;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      pc_d    = tgt;
      valid_d = 1'b0;
    end
  end

  // An ungranted request keeps its address even when pc_q moves to a redirect target.
  assign addr_d = (state_q == S_REQ && !imem_gnt_i) ? addr_q : pc_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      out_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      out_addr_q <= out_addr_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      mis_q      <= redirect & tgt_raw[1];
    end
  end

  assign redirect_o  = redirect;
  assign misalign_o  = mis_q;
  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = addr_q;
  assign if_valid_o  = valid_q;
  assign if_instr_o  = instr_q;
  assign if_pc_o     = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - bench for fetch_unit with a memory model and delivery-order reference
// Memory returns each word's address as data; the reference tracks the PC decode must see next.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i, ex_is_branch_i, branch_i, ex_jal_i, ex_jalr_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_rs1_i;
  logic        redirect_o, misalign_o, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i, if_instr_o, if_pc_o;
  logic        if_valid_o, id_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(.DW(32), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .branch_i(branch_i),
    .ex_jal_i(ex_jal_i), .ex_jalr_i(ex_jalr_i),
    .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs1_i(ex_rs1_i),
    .redirect_o(redirect_o), .misalign_o(misalign_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .id_ready_i(id_ready_i)
  );

  int          total = 0, bad = 0;
  logic [31:0] exp_pc, pend_addr, prev_addr;
  bit          pend, prev_mis, prev_redir, prev_stall, last_valid;
  logic [31:0] grants[$];
  int          ndeliv = 0;
  int          gnt_pct = 100, rv_pct = 100;
  bit          rv_hold = 0, stray = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RST_PC; pend = 0; prev_mis = 0; prev_redir = 0; prev_stall = 0;
  endtask

  task automatic clear_ex();
    ex_valid_i = 0; ex_is_branch_i = 0; branch_i = 0; ex_jal_i = 0; ex_jalr_i = 0;
    ex_pc_i = 0; ex_imm_i = 0; ex_rs1_i = 0;
  endtask

  task automatic monitor();
    bit          redir;
    logic [31:0] tgt;
    redir = ex_valid_i && ((ex_is_branch_i && branch_i) || ex_jal_i || ex_jalr_i);
    tgt = ex_jalr_i ? ((ex_rs1_i + ex_imm_i) & ~32'd1) : (ex_pc_i + ex_imm_i);
    check("redirect", redirect_o, redir);
    check("misalign", misalign_o, prev_mis);
    if (prev_redir) check("flush", if_valid_o, 0);
    if (imem_req_o) begin
      check("addr_align", imem_addr_o & 32'd3, 0);
      check("single_outstanding", pend, 0);
    end
    if (prev_stall && imem_req_o) check("addr_stable", imem_addr_o, prev_addr);
    if (if_valid_o && id_ready_i && !redir) begin
      check("deliver_pc", if_pc_o, exp_pc);
      check("deliver_instr", if_instr_o, exp_pc);
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end
    if (imem_rvalid_i) pend = 0;
    if (imem_req_o && imem_gnt_i) begin
      pend = 1; pend_addr = imem_addr_o; grants.push_back(imem_addr_o);
    end
    if (redir) exp_pc = tgt & ~32'd3;
    prev_mis   = redir && tgt[1];
    prev_redir = redir;
    prev_stall = imem_req_o && !imem_gnt_i && !rst_i;
    prev_addr  = imem_addr_o;
    last_valid = if_valid_o;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic step();
    imem_gnt_i = imem_req_o && ($urandom_range(99) < gnt_pct);
    if (stray) begin
      imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
    end else if (pend && !rv_hold && ($urandom_range(99) < rv_pct)) begin
      imem_rvalid_i = 1; imem_rdata_i = pend_addr;
    end else begin
      imem_rvalid_i = 0; imem_rdata_i = $urandom;
    end
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pend();
    for (int k = 0; k < 40 && !pend; k++) step();
    check("wait_pend", pend, 1);
  endtask

  task automatic wait_grants(int n);
    for (int k = 0; k < 60 && grants.size() < n; k++) step();
    check("wait_grants", grants.size() >= n, 1);
  endtask

  initial begin
    int          gsz, nd0;
    logic [31:0] vpat, hold_pc, hold_instr;
    clear_ex();
    id_ready_i = 1; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, RST_PC);
    check("rst_valid", if_valid_o, 0);
    check("rst_instr", if_instr_o, 0);
    check("rst_pc", if_pc_o, 0);
    check("rst_misalign", misalign_o, 0);

    // Zero-wait sequential fetch
    rst_i = 0;
    check("idle_first_cycle", imem_req_o, 0);
    vpat = 0;
    step();
    vpat[0] = last_valid;
    check("first_req", imem_req_o, 1);
    check("first_addr", imem_addr_o, RST_PC);
    for (int i = 1; i < 8; i++) begin
      step();
      vpat[i] = last_valid;
    end
    check("valid_pattern", vpat, 32'b1010_1000);
    check("deliv3", ndeliv, 3);
    check("grant0", grants[0], 32'h0);
    check("grant1", grants[1], 32'h4);
    check("grant2", grants[2], 32'h8);

    // Taken branch while a request waits for its response
    rv_hold = 1;
    wait_pend();
    ex_valid_i = 1; ex_is_branch_i = 1; branch_i = 1; ex_pc_i = 32'h100; ex_imm_i = 32'hFFFF_FFF0;
    step();
    clear_ex();
    rv_hold = 0;
    gsz = grants.size();
    wait_grants(gsz + 1);
    check("branch_next_req", grants[gsz], 32'hF0);
    nd0 = ndeliv;
    repeat (6) step();
    check("branch_progress", ndeliv > nd0, 1);

    // Not-taken branch leaves the sequential stream alone
    ex_valid_i = 1; ex_is_branch_i = 1; branch_i = 0; ex_pc_i = 32'h400; ex_imm_i = 32'h40;
    step();
    clear_ex();
    nd0 = ndeliv;
    repeat (8) step();
    check("not_taken_progress", ndeliv > nd0, 1);

    // JALR to a half-word target
    ex_valid_i = 1; ex_jalr_i = 1; ex_rs1_i = 32'h203; ex_imm_i = 32'h0;
    gsz = grants.size();
    step();
    clear_ex();
    check("jalr_misalign_pulse", misalign_o, 1);
    step();
    check("jalr_misalign_end", misalign_o, 0);
    gsz = grants.size();
    wait_grants(gsz + 1);
    check("jalr_fetch", grants[gsz], 32'h200);
    repeat (4) step();

    // Decode stall with an instruction buffered
    for (int k = 0; k < 20 && !if_valid_o; k++) step();
    check("stall_setup", if_valid_o, 1);
    hold_pc = if_pc_o; hold_instr = if_instr_o;
    id_ready_i = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", if_valid_o, 1);
      check("stall_pc", if_pc_o, hold_pc);
      check("stall_instr", if_instr_o, hold_instr);
      if (k >= 1) check("stall_no_req", imem_req_o, 0);
    end
    id_ready_i = 1;
    nd0 = ndeliv;
    repeat (10) step();
    check("stall_resume", ndeliv - nd0 >= 3, 1);

    // Address wrap at the top of memory
    ex_valid_i = 1; ex_jal_i = 1; ex_pc_i = 32'h0; ex_imm_i = 32'hFFFF_FFF8;
    step();
    clear_ex();
    gsz = grants.size();
    wait_grants(gsz + 3);
    check("wrap_a", grants[gsz], 32'hFFFF_FFF8);
    check("wrap_b", grants[gsz + 1], 32'hFFFF_FFFC);
    check("wrap_c", grants[gsz + 2], 32'h0);
    repeat (4) step();

    // Reset while waiting, with a late response after release
    rv_hold = 1;
    wait_pend();
    rst_i = 1;
    model_reset();
    step();
    check("midrst_req", imem_req_o, 0);
    check("midrst_addr", imem_addr_o, RST_PC);
    check("midrst_valid", if_valid_o, 0);
    rst_i = 0; rv_hold = 0; stray = 1; gnt_pct = 0;
    repeat (2) step();
    stray = 0; gnt_pct = 100;
    gsz = grants.size();
    wait_grants(gsz + 1);
    check("restart_addr", grants[gsz], RST_PC);
    nd0 = ndeliv;
    repeat (6) step();
    check("restart_progress", ndeliv > nd0, 1);

    // Random memory latency, decode stalls and redirects
    gnt_pct = 60; rv_pct = 50;
    nd0 = ndeliv;
    for (int c = 0; c < 800; c++) begin
      id_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(11) == 0) begin
        ex_valid_i = 1; ex_is_branch_i = 1'($urandom_range(1)); branch_i = 1'($urandom_range(1));
        ex_jal_i = ($urandom_range(3) == 0); ex_jalr_i = ($urandom_range(3) == 0);
        ex_pc_i = $urandom; ex_imm_i = 32'($urandom_range(255)) - 32'd128; ex_rs1_i = $urandom;
      end else begin
        clear_ex();
        ex_valid_i = 1'($urandom_range(1)); ex_is_branch_i = 1'($urandom_range(1));
      end
      step();
    end
    clear_ex();
    id_ready_i = 1;
    check("random_progress", ndeliv - nd0 > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
